// File: rtl/difftest_commit_pkg.sv
// ---------------------------------------------------------------------------
// difftest_commit_pkg
// Shared types and helpers for the difftest commit scheduler.
//   commit_rec_t : packed layout of one 160-bit commit record
//   IDX_W        : width of each probe index output
//   clog2        : constant ceil(log2) helper for parameter math
// ---------------------------------------------------------------------------
package difftest_commit_pkg;

  localparam int IDX_W     = 8;
  localparam int REC_W_DEF = 160;

  // 127 bits of payload, padded up to the 160-bit record width.
  typedef struct packed {
    logic [32:0] padding;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [9:0]  robIdx;
    logic [7:0]  wdest;
    logic [7:0]  wpdest;
    logic        isRVC;
    logic        rfwen;
    logic        fpwen;
    logic        vecwen;
    logic        skip;
  } commit_rec_t;

  // Smallest r with 2**r >= value; valid for value in 1 .. 2**31.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/difftest_commit_compact.sv
// ---------------------------------------------------------------------------
// difftest_commit_compact
// Purely combinational compaction of a sparse commit group.
//   i_valid  : per-slot valid, may be sparse
//   i_rec    : slot i at [i*REC_W +: REC_W]
//   o_dense  : valid records packed into slots 0..o_count-1, ascending order
//   o_count  : number of valid slots (popcount of i_valid)
// Each valid slot lands at the position given by the popcount of the valid
// bits below it, so relative order is preserved.
// ---------------------------------------------------------------------------
module difftest_commit_compact
  import difftest_commit_pkg::*;
#(
  parameter  int IN_W  = 8,
  parameter  int REC_W = 160,
  localparam int CNT_W = clog2(IN_W) + 1
) (
  input  logic [IN_W-1:0]       i_valid,
  input  logic [IN_W*REC_W-1:0] i_rec,
  output logic [IN_W*REC_W-1:0] o_dense,
  output logic [CNT_W-1:0]      o_count
);

  logic [CNT_W-1:0] w_prefix [IN_W];

  // Exclusive prefix popcount per slot; the running total is the group count.
  always_comb begin
    logic [CNT_W-1:0] v_run;
    v_run = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_prefix[i] = v_run;
      v_run       = v_run + CNT_W'(i_valid[i]);
    end
    o_count = v_run;
  end

  // One-hot OR mux: dense slot j takes the valid input whose prefix equals j.
  always_comb begin
    o_dense = '0;
    for (int j = 0; j < IN_W; j++) begin
      for (int i = 0; i < IN_W; i++) begin
        o_dense[j*REC_W +: REC_W] = o_dense[j*REC_W +: REC_W] |
          ((i_valid[i] && (w_prefix[i] == CNT_W'(j))) ? i_rec[i*REC_W +: REC_W] : {REC_W{1'b0}});
      end
    end
  end

endmodule

// File: rtl/difftest_commit_scheduler.sv
// ---------------------------------------------------------------------------
// difftest_commit_scheduler
// Packs sparse ROB commit groups into a circular buffer in program order and
// drains at most OUT_W records per cycle onto the difftest probe slots.
//   clock, reset_n : clock, asynchronous active-low reset
//   in_valid/in_rec: sparse commit group; in_ready = room for a full group
//   drain_en       : 0 pauses output while the buffer keeps filling
//   flush          : drops buffered and incoming records
//   out_enable/out_rec/out_index : registered probe outputs
//   occupancy      : buffered entry count
//   overflow       : sticky, a valid group was offered while in_ready=0
// ---------------------------------------------------------------------------
module difftest_commit_scheduler
  import difftest_commit_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2,
  parameter int DEPTH = 32,
  parameter int REC_W = 160
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [IN_W-1:0]           in_valid,
  input  logic [IN_W*REC_W-1:0]     in_rec,
  output logic                      in_ready,
  input  logic                      drain_en,
  input  logic                      flush,
  output logic [OUT_W-1:0]          out_enable,
  output logic [OUT_W*REC_W-1:0]    out_rec,
  output logic [OUT_W*IDX_W-1:0]    out_index,
  output logic [clog2(DEPTH):0]     occupancy,
  output logic                      overflow
);

  localparam int PTR_W = clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;
  localparam int CNT_W = clog2(IN_W) + 1;

  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [REC_W-1:0]         r_mem [DEPTH];
  logic [OUT_W-1:0]         r_out_enable;
  logic [OUT_W*REC_W-1:0]   r_out_rec;
  logic [OUT_W*IDX_W-1:0]   r_out_index;
  logic                     r_overflow;

  logic [IN_W*REC_W-1:0]    w_dense;
  logic [CNT_W-1:0]         w_count;
  logic [PTR_W-1:0]         w_occ;
  logic [PTR_W-1:0]         w_free;
  logic [PTR_W-1:0]         w_n;
  logic                     w_accept;
  logic                     w_ovf_set;
  logic [AW-1:0]            w_waddr [IN_W];
  logic [AW-1:0]            w_raddr [OUT_W];

  difftest_commit_compact #(
    .IN_W  (IN_W),
    .REC_W (REC_W)
  ) u_compact (
    .i_valid (in_valid),
    .i_rec   (in_rec),
    .o_dense (w_dense),
    .o_count (w_count)
  );

  // Occupancy, flow control and drain count; all derived from registered pointers.
  always_comb begin
    w_occ     = r_wr_ptr - r_rd_ptr;
    w_free    = PTR_W'(DEPTH) - w_occ;
    in_ready  = (w_free >= PTR_W'(IN_W));
    w_accept  = in_ready & (|in_valid) & ~flush;
    w_ovf_set = (|in_valid) & ~in_ready & ~flush;
    if (flush || !drain_en) begin
      w_n = '0;
    end else if (w_occ < PTR_W'(OUT_W)) begin
      w_n = w_occ;
    end else begin
      w_n = PTR_W'(OUT_W);
    end
  end

  // Buffer addresses; the wrap bit is dropped so indices wrap modulo DEPTH.
  always_comb begin
    for (int j = 0; j < IN_W; j++) begin
      w_waddr[j] = AW'(r_wr_ptr + PTR_W'(j));
    end
    for (int i = 0; i < OUT_W; i++) begin
      w_raddr[i] = AW'(r_rd_ptr + PTR_W'(i));
    end
  end

  // Storage write of the compacted group; contents need no reset.
  always_ff @(posedge clock) begin
    for (int j = 0; j < IN_W; j++) begin
      if (w_accept && (CNT_W'(j) < w_count)) begin
        r_mem[w_waddr[j]] <= w_dense[j*REC_W +: REC_W];
      end
    end
  end

  // Pointers, registered probe outputs and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_enable <= '0;
      r_out_rec    <= '0;
      r_out_index  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_out_enable <= '0;
        r_out_rec    <= '0;
        r_out_index  <= '0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(w_count);
        end
        r_rd_ptr <= r_rd_ptr + w_n;
        // Drain reads pre-edge contents only; same-edge writes are not bypassed.
        for (int i = 0; i < OUT_W; i++) begin
          if (PTR_W'(i) < w_n) begin
            r_out_enable[i]                <= 1'b1;
            r_out_rec[i*REC_W +: REC_W]    <= r_mem[w_raddr[i]];
            r_out_index[i*IDX_W +: IDX_W]  <= IDX_W'(i);
          end else begin
            r_out_enable[i]                <= 1'b0;
            r_out_rec[i*REC_W +: REC_W]    <= '0;
            r_out_index[i*IDX_W +: IDX_W]  <= '0;
          end
        end
      end
    end
  end

  assign occupancy  = w_occ;
  assign out_enable = r_out_enable;
  assign out_rec    = r_out_rec;
  assign out_index  = r_out_index;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_difftest_commit_scheduler.sv
// Self-checking bench for difftest_commit_scheduler: a directed vector table
// for the opening sequence, hand-written corner-case sequences, and a record
// scoreboard fed when groups are offered and drained when probes fire.
module tb_difftest_commit_scheduler;
  import difftest_commit_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = 2;
  localparam int DEPTH = 32;
  localparam int REC_W = 160;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [IN_W-1:0]        in_valid;
  logic [IN_W*REC_W-1:0]  in_rec;
  logic                   in_ready;
  logic                   drain_en;
  logic                   flush;
  logic [OUT_W-1:0]       out_enable;
  logic [OUT_W*REC_W-1:0] out_rec;
  logic [OUT_W*8-1:0]     out_index;
  logic [5:0]             occupancy;
  logic                   overflow;

  difftest_commit_scheduler #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .REC_W(REC_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_rec     (in_rec),
    .in_ready   (in_ready),
    .drain_en   (drain_en),
    .flush      (flush),
    .out_enable (out_enable),
    .out_rec    (out_rec),
    .out_index  (out_index),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [REC_W-1:0] exp_q[$];
  int m_occ;
  bit m_ovf;

  typedef struct {
    logic [7:0]  v;
    logic [63:0] base;
    bit          drain;
    bit          fl;
    int          occ;
    logic [1:0]  en;
    bit          rdy;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [63:0] pc, input int slot);
    commit_rec_t r;
    r        = '0;
    r.pc     = pc;
    r.instr  = pc[31:0] ^ 32'hDEAD_BEEF;
    r.robIdx = 10'(slot);
    r.wdest  = 8'(slot * 3);
    r.isRVC  = pc[0];
    r.rfwen  = 1'b1;
    return r;
  endfunction

  // Drive one cycle, update the reference model, then check after the edge.
  task automatic cycle(input logic [7:0] v, input logic [63:0] base, input bit drain, input bit fl);
    int k;
    int n;
    bit rdy;
    bit acc;
    logic [OUT_W-1:0] mask;
    in_valid = v;
    drain_en = drain;
    flush    = fl;
    for (int i = 0; i < IN_W; i++) in_rec[i*REC_W +: REC_W] = mk_rec(base + 64'(i), i);
    k   = $countones(v);
    rdy = (DEPTH - m_occ) >= IN_W;
    acc = rdy && (v != 8'h00) && !fl;
    if (fl || !drain) n = 0;
    else n = (m_occ < OUT_W) ? m_occ : OUT_W;
    if ((v != 8'h00) && !rdy && !fl) m_ovf = 1'b1;
    if (fl) begin
      exp_q.delete();
      m_occ = 0;
    end else begin
      if (acc) begin
        for (int i = 0; i < IN_W; i++) if (v[i]) exp_q.push_back(in_rec[i*REC_W +: REC_W]);
      end
      m_occ = m_occ + (acc ? k : 0) - n;
    end
    @(posedge clock);
    #1;
    chk("occupancy", occupancy, m_occ);
    chk("in_ready", in_ready, ((DEPTH - m_occ) >= IN_W));
    chk("overflow", overflow, m_ovf);
    for (int i = 0; i < OUT_W; i++) mask[i] = (i < n);
    chk("out_enable", out_enable, mask);
    for (int i = 0; i < OUT_W; i++) begin
      if (i < n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: slot %0d fired with nothing expected", i);
        end else begin
          chk("out_rec", out_rec[i*REC_W +: REC_W], exp_q.pop_front());
        end
        chk("out_index", out_index[i*8 +: 8], 8'(i));
      end else begin
        chk("out_rec_idle", out_rec[i*REC_W +: REC_W], '0);
        chk("out_index_idle", out_index[i*8 +: 8], 8'h00);
      end
    end
  endtask

  initial begin
    tbl[0] = '{8'h01, 64'h8000_0000, 1'b1, 1'b0, 1, 2'b00, 1'b1};
    tbl[1] = '{8'h00, 64'h0,         1'b1, 1'b0, 0, 2'b01, 1'b1};
    tbl[2] = '{8'hA5, 64'h0,         1'b1, 1'b0, 4, 2'b00, 1'b1};
    tbl[3] = '{8'h00, 64'h0,         1'b1, 1'b0, 2, 2'b11, 1'b1};
    tbl[4] = '{8'h00, 64'h0,         1'b1, 1'b0, 0, 2'b11, 1'b1};
    tbl[5] = '{8'h00, 64'h0,         1'b1, 1'b0, 0, 2'b00, 1'b1};

    reset_n  = 1'b0;
    in_valid = '0;
    in_rec   = '0;
    drain_en = 1'b0;
    flush    = 1'b0;
    m_occ    = 0;
    m_ovf    = 1'b0;
    #12;
    chk("reset_en", out_enable, 2'b00);
    chk("reset_occ", occupancy, 6'd0);
    chk("reset_ready", in_ready, 1'b1);
    chk("reset_ovf", overflow, 1'b0);
    chk("reset_index", out_index, 16'h0000);
    reset_n = 1'b1;

    // Single record then sparse ordering, table driven.
    for (int t = 0; t < 6; t++) begin
      cycle(tbl[t].v, tbl[t].base, tbl[t].drain, tbl[t].fl);
      chk("tbl_occ", occupancy, tbl[t].occ);
      chk("tbl_en", out_enable, tbl[t].en);
      chk("tbl_ready", in_ready, tbl[t].rdy);
    end

    // Fill with drain paused, then overflow on a fifth group.
    for (int g = 0; g < 4; g++) cycle(8'hFF, 64'h1000 + 64'(g * 8), 1'b0, 1'b0);
    chk("full_occ", occupancy, 6'd32);
    chk("full_ready", in_ready, 1'b0);
    cycle(8'hFF, 64'h2000, 1'b0, 1'b0);
    chk("overflow_set", overflow, 1'b1);
    chk("overflow_occ", occupancy, 6'd32);
    for (int c = 0; c < 16; c++) cycle(8'h00, 64'h0, 1'b1, 1'b0);
    chk("fill_drained", exp_q.size(), 0);

    // Random sparse traffic across pointer wrap-around.
    for (int c = 0; c < 50; c++) begin
      cycle(8'($urandom) & 8'($urandom), 64'h10000 + 64'(c * 16), 1'b1, 1'b0);
      chk("occ_bound", (occupancy <= 6'd32), 1'b1);
    end
    for (int c = 0; c < 40 && m_occ > 0; c++) cycle(8'h00, 64'h0, 1'b1, 1'b0);
    chk("wrap_drained", exp_q.size(), 0);

    // Flush with 12 buffered and a group of 3 offered.
    cycle(8'hFF, 64'h3000, 1'b0, 1'b0);
    cycle(8'h0F, 64'h3100, 1'b0, 1'b0);
    chk("pre_flush_occ", occupancy, 6'd12);
    cycle(8'h07, 64'h3200, 1'b1, 1'b1);
    chk("flush_occ", occupancy, 6'd0);
    chk("flush_en", out_enable, 2'b00);
    for (int c = 0; c < 3; c++) cycle(8'h00, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset while both probes fire.
    cycle(8'hFF, 64'h4000, 1'b0, 1'b0);
    cycle(8'h00, 64'h0, 1'b1, 1'b0);
    chk("pre_rst_en", out_enable, 2'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_en", out_enable, 2'b00);
    chk("rst_rec", (out_rec == '0), 1'b1);
    chk("rst_index", out_index, 16'h0000);
    chk("rst_occ", occupancy, 6'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    exp_q.delete();
    m_occ = 0;
    m_ovf = 1'b0;
    #1;
    reset_n = 1'b1;
    cycle(8'h01, 64'h5000, 1'b1, 1'b0);
    cycle(8'h00, 64'h0, 1'b1, 1'b0);
    chk("post_rst_ovf", overflow, 1'b0);
    chk("post_rst_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/difftest_commit_scheduler.md
Name: difftest_commit_scheduler

Overview:
- Sits between the ROB commit ports and the bank of per-slot instruction-commit difftest probes.
- Each cycle it accepts up to IN_W sparse commit records and packs them in program order into a circular buffer.
- It drains at most OUT_W records per cycle into probe slots 0..OUT_W-1, driving each probe's enable and index.
- The DPI side therefore sees a dense, in-order, rate-limited commit stream.

Parameters:
- IN_W, 8, commit slots presented per cycle
- OUT_W, 2, probe instances driven per cycle
- DEPTH, 32, buffer entries; power of two, DEPTH >= 2*IN_W
- REC_W, 160, opaque packed commit-record width (pc, instr, robIdx, wdest, flags)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  IN_W  per-slot commit valid; may be sparse, e.g. 8'b1010_0101
- in_rec  in  IN_W*REC_W  slot i occupies bits [i*REC_W +: REC_W]
- in_ready  out  1  the whole group is accepted this cycle
- drain_en  in  1  0 pauses output (difftest pause); buffer keeps filling
- flush  in  1  drops all buffered and incoming records
- out_enable  out  OUT_W  probe i fires this cycle
- out_rec  out  OUT_W*REC_W  record for probe i
- out_index  out  OUT_W*8  probe index; constant i when enabled, 0 otherwise
- occupancy  out  clog2(DEPTH)+1  buffered entry count
- overflow  out  1  sticky; a valid group arrived while in_ready=0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - rd_ptr, wr_ptr and occupancy go to 0.
  - out_enable, out_rec, out_index and overflow go to 0.
  - in_ready goes to 1.
  - Reset mid-operation discards all contents immediately.
- in_ready:
  - Combinational: (DEPTH - occupancy) >= IN_W.
  - Depends only on registered state, never on in_valid.
- Accept = in_ready & |in_valid & ~flush.
- On accept, the k = popcount(in_valid) valid slots are compacted in ascending slot order.
  - They are written at wr_ptr .. wr_ptr+k-1, modulo DEPTH.
  - wr_ptr advances by k.
- Drain: n = drain_en ? min(occupancy, OUT_W) : 0.
  - Entries rd_ptr .. rd_ptr+n-1 are registered onto out slots 0..n-1.
  - out_enable[i] = (i < n).
  - Disabled slots drive out_rec = 0.
  - rd_ptr advances by n, modulo DEPTH.
  - Outputs are registered: a record drained at edge t is valid on out_* during cycle t+1 only.
- Latency: a record accepted at edge t is eligible to drain at edge t+1, so the minimum is 2 cycles from in_valid to out_enable.
- Simultaneous accept and drain:
  - Both happen on the same edge.
  - occupancy_next = occupancy + k - n.
  - Drain reads only pre-edge contents; there is no bypass.
- Pointers are clog2(DEPTH)+1 bits wide, with a wrap bit.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - occupancy = wr_ptr - rd_ptr, computed at full pointer width.
- Order: global program order is preserved across cycles and wrap-around.
- flush:
  - Takes precedence over accept and drain.
  - Pointers and occupancy go to 0 on the next edge.
  - out_enable goes to 0 on the next edge.
  - The in group presented in that cycle is discarded and overflow is unaffected.
- overflow:
  - Set when |in_valid & ~in_ready & ~flush.
  - Cleared only by reset.
  - The offered group is dropped.
- drain_en=0 holds rd_ptr and drives out_enable to 0 on the next edge.
- A group with in_valid = 0 is a no-op.

Decomposition:
- Package difftest_commit_pkg holds:
  - the commit_rec_t packed struct (pc 64, instr 32, robIdx 10, wdest 8, wpdest 8, isRVC, rfwen, fpwen, vecwen, skip, padding to REC_W)
  - the IDX_W constant
  - a clog2 helper
- Sub-module difftest_commit_compact:
  - Combinational.
  - Converts in_valid/in_rec into dense slots plus count k, using a prefix-popcount per slot.
- The top level holds the storage array, pointers and output registers.

Test Plan:
- Single record: reset; in_valid=8'h01, pc=0x8000_0000 for one cycle -> out_enable=2'b01 with that pc exactly 2 cycles later, out_index[0]=0, occupancy returns to 0.
- Sparse ordering: in_valid=8'b1010_0101 carrying pc tags 0,2,5,7 -> out_enable=2'b11 for 2 consecutive cycles, emitting tags (0,2) then (5,7).
- Fill and backpressure: drain_en=0, full groups of 8 for 4 cycles -> occupancy=32, in_ready=0. A fifth group -> overflow=1 and the group is dropped. Then drain_en=1 -> 16 drain cycles emit tags 0..31 in order.
- Wrap-around: 50 cycles of random sparse groups with drain_en=1 -> the output tag stream equals the input stream in order, with no loss and no duplication; occupancy never exceeds 32.
- Flush during traffic: occupancy=12 and a group of 3 offered with flush=1 -> next cycle occupancy=0 and out_enable=0; the 3 records never appear.
- Async reset mid-drain: reset_n low while out_enable=2'b11 -> outputs go to 0 without waiting for a clock edge; after release in_ready=1 and overflow=0.
